// File: rtl/ysyx_2022040010_lsu_pkg.sv
// Shared encodings for the load/store unit: access size, FSM state, default bus timeout.
package ysyx_2022040010_lsu_pkg;

   typedef enum logic [1:0] {
      LSU_SIZE_B = 2'd0,
      LSU_SIZE_H = 2'd1,
      LSU_SIZE_W = 2'd2,
      LSU_SIZE_D = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   localparam int LSU_TIMEOUT = 255;

endpackage

// File: rtl/ysyx_2022040010_lsu_if.sv
// Data-SRAM bus: valid/ready request channel plus a valid-only response beat.
interface ysyx_2022040010_lsu_if;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

endinterface

// File: rtl/ysyx_2022040010_lsu_align.sv
// Combinational: size + low address bits -> byte mask, lane-shifted store data, misalign flag.
// Zero latency, no flow control.
module ysyx_2022040010_lsu_align
   import ysyx_2022040010_lsu_pkg::*;
(
   input  lsu_size_e   size,
   input  logic [2:0]  addr_lo,
   input  logic [63:0] wdata,
   output logic [7:0]  mask,
   output logic [63:0] wdata_sh,
   output logic        misalign
);

   always_comb begin
      mask     = 8'h00;
      misalign = 1'b0;
      case (size)
         LSU_SIZE_B: mask = 8'h01 << addr_lo;
         LSU_SIZE_H: begin
            mask     = 8'h03 << addr_lo;
            misalign = addr_lo[0];
         end
         LSU_SIZE_W: begin
            mask     = 8'h0F << addr_lo;
            misalign = |addr_lo[1:0];
         end
         default: begin
            mask     = 8'hFF;
            misalign = |addr_lo;
         end
      endcase
   end

   assign wdata_sh = wdata << {addr_lo, 3'b000};

endmodule

// File: rtl/ysyx_2022040010_lsu.sv
// Load/store unit: EX request -> one valid/ready SRAM transaction, stalling IF..EX while outstanding.
// >=2 cycles accept->lsu_done; request held stable until mem_req_ready; TIMEOUT cycles forces bus_err.
module ysyx_2022040010_lsu
   import ysyx_2022040010_lsu_pkg::*;
#(
   parameter int TIMEOUT = LSU_TIMEOUT,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ex_valid,
   input  logic                         ex_we,
   input  logic [1:0]                   ex_size,
   input  logic [63:0]                  ex_addr,
   input  logic [63:0]                  ex_wdata,
   ysyx_2022040010_lsu_if.master        mem,
   output logic                         stall_req,
   output logic                         lsu_done,
   output logic [63:0]                  dsram_rdata,
   output logic [7:0]                   dsram_sel,
   output logic                         bus_err,
   output logic                         misalign
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

   lsu_state_e       state_q, state_d;
   logic [63:0]      addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      rdata_q, rdata_d;
   logic [7:0]       wstrb_q, wstrb_d;
   logic [7:0]       sel_q, sel_d;
   logic             we_q, we_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [7:0]       al_mask;
   logic [63:0]      al_wdata;
   logic             al_mis;
   logic             accept;
   logic             timeout;

   ysyx_2022040010_lsu_align u_align (
      .size     (lsu_size_e'(ex_size)),
      .addr_lo  (ex_addr[2:0]),
      .wdata    (ex_wdata),
      .mask     (al_mask),
      .wdata_sh (al_wdata),
      .misalign (al_mis)
   );

   // rst gates the IDLE-side outputs so nothing leaks out while EX is held valid in reset
   assign accept  = rst && (state_q == LSU_IDLE) && ex_valid && !al_mis;
   assign timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (accept) begin
               addr_d  = {ex_addr[63:3], 3'b000};
               wdata_d = al_wdata;
               wstrb_d = al_mask;
               we_d    = ex_we;
               cnt_d   = '0;
               state_d = LSU_REQ;
            end
         end
         LSU_REQ, LSU_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem.mem_rsp_valid && (state_q == LSU_WAIT || mem.mem_req_ready)) begin
               rdata_d = we_q ? 64'd0 : mem.mem_rsp_rdata;
               sel_d   = wstrb_q;
               state_d = LSU_DONE;
            end else if (timeout) begin
               rdata_d = 64'd0;
               sel_d   = wstrb_q;
               err_d   = 1'b1;
               state_d = LSU_DONE;
            end else if (state_q == LSU_REQ && mem.mem_req_ready) begin
               state_d = LSU_WAIT;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LSU_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign mem.mem_req_valid = (state_q == LSU_REQ);
   assign mem.mem_addr      = addr_q;
   assign mem.mem_we        = we_q;
   assign mem.mem_wdata     = wdata_q;
   assign mem.mem_wstrb     = wstrb_q;

   assign stall_req   = accept || (state_q == LSU_REQ) || (state_q == LSU_WAIT);
   assign lsu_done    = (state_q == LSU_DONE);
   assign bus_err     = err_q;
   assign dsram_rdata = rdata_q;
   assign dsram_sel   = sel_q;
   assign misalign    = rst && (state_q == LSU_IDLE) && ex_valid && al_mis;

endmodule

// File: tb/tb_ysyx_2022040010_lsu.sv
// Bench for ysyx_2022040010_lsu: vector table driven through a bus responder, completions scoreboarded.
module tb_ysyx_2022040010_lsu;

   logic        clk, rst, ex_valid, ex_we;
   logic [1:0]  ex_size;
   logic [63:0] ex_addr, ex_wdata;
   logic        stall_req, lsu_done, bus_err, misalign;
   logic [63:0] dsram_rdata;
   logic [7:0]  dsram_sel;

   ysyx_2022040010_lsu_if bus();

   ysyx_2022040010_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_size(ex_size),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .mem(bus), .stall_req(stall_req),
      .lsu_done(lsu_done), .dsram_rdata(dsram_rdata), .dsram_sel(dsram_sel),
      .bus_err(bus_err), .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          rdy_dly;
      int          rsp_dly;
      logic [63:0] rdata;
      logic        exp_mis;
      logic [63:0] exp_addr;
      logic [7:0]  exp_sel;
      logic [63:0] exp_wdata;
      int          exp_stall;
      logic        exp_err;
      logic [63:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic [7:0]  sel;
      logic        err;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[10];
   vec_t v_tmo;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  stall_cnt = 0;
      int  wait_n    = 0;
      int  acc       = -1;
      bit  first     = 1'b1;
      bit  done      = 1'b0;
      sb_t e;
      @(negedge clk);
      ex_valid = 1'b1; ex_we = v.we; ex_size = v.size; ex_addr = v.addr; ex_wdata = v.wdata;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_misalign", idx), 64'(misalign), 64'(v.exp_mis));
      if (v.exp_mis) begin
         chk($sformatf("v%0d_mis_stall", idx), 64'(stall_req), 64'd0);
         @(negedge clk);
         ex_valid = 1'b0;
         #1;
         chk($sformatf("v%0d_mis_noreq", idx), 64'({bus.mem_req_valid, stall_req, lsu_done}), 64'd0);
         return;
      end
      if (stall_req) stall_cnt++;
      sb_q.push_back('{rdata: v.exp_rdata, sel: v.exp_sel, err: v.exp_err});
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         #1;
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
         if (bus.mem_req_valid) begin
            if (first) begin
               chk($sformatf("v%0d_addr", idx), bus.mem_addr, v.exp_addr);
               chk($sformatf("v%0d_we", idx), 64'(bus.mem_we), 64'(v.we));
               chk($sformatf("v%0d_wstrb", idx), 64'(bus.mem_wstrb), 64'(v.exp_sel));
               chk($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.exp_wdata);
               first = 1'b0;
            end
            if (wait_n == v.rdy_dly) begin
               bus.mem_req_ready = 1'b1;
               acc = c;
            end else begin
               wait_n++;
            end
         end
         if (acc >= 0 && c - acc == v.rsp_dly) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = v.rdata;
         end
         #1;
         if (stall_req) stall_cnt++;
         if (lsu_done) begin
            done = 1'b1;
            if (sb_q.size() == 0) begin
               chk($sformatf("v%0d_sb_underflow", idx), 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("v%0d_rdata", idx), dsram_rdata, e.rdata);
               chk($sformatf("v%0d_sel", idx), 64'(dsram_sel), 64'(e.sel));
               chk($sformatf("v%0d_bus_err", idx), 64'(bus_err), 64'(e.err));
            end
            chk($sformatf("v%0d_stall_cycles", idx), 64'(stall_cnt), 64'(v.exp_stall));
         end
      end
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL v%0d_done_timeout: lsu_done never seen, want pulse within 20 cycles", idx);
         void'(sb_q.pop_back());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 2'b10, 64'h8000_0004, 64'h0, 0, 2, 64'h1122_3344_5566_7788,
                  1'b0, 64'h8000_0000, 8'hF0, 64'h0, 4, 1'b0, 64'h1122_3344_5566_7788};
      vecs[1] = '{1'b1, 2'b00, 64'h8000_0003, 64'hAB, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                  1'b0, 64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000, 4, 1'b0, 64'h0};
      vecs[2] = '{1'b0, 2'b10, 64'h8000_0002, 64'h0, 0, 0, 64'h0,
                  1'b1, 64'h0, 8'h00, 64'h0, 0, 1'b0, 64'h0};
      vecs[3] = '{1'b0, 2'b11, 64'h8000_0008, 64'h0, 0, 0, 64'h0123_4567_89AB_CDEF,
                  1'b0, 64'h8000_0008, 8'hFF, 64'h0, 2, 1'b0, 64'h0123_4567_89AB_CDEF};
      vecs[4] = '{1'b1, 2'b01, 64'h8000_0016, 64'h1234_5678_9ABC_BEEF, 2, 1, 64'h5555_5555_5555_5555,
                  1'b0, 64'h8000_0010, 8'hC0, 64'hBEEF_0000_0000_0000, 5, 1'b0, 64'h0};
      vecs[5] = '{1'b0, 2'b01, 64'h8000_0001, 64'h0, 0, 0, 64'h0,
                  1'b1, 64'h0, 8'h00, 64'h0, 0, 1'b0, 64'h0};
      vecs[6] = '{1'b0, 2'b11, 64'h8000_0004, 64'h0, 0, 0, 64'h0,
                  1'b1, 64'h0, 8'h00, 64'h0, 0, 1'b0, 64'h0};
      vecs[7] = '{1'b0, 2'b00, 64'h8000_0007, 64'h0, 0, 3, 64'hA5A5_A5A5_A5A5_A5A5,
                  1'b0, 64'h8000_0000, 8'h80, 64'h0, 5, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
      vecs[8] = '{1'b1, 2'b10, 64'h8000_000C, 64'hCAFE_F00D, 3, 0, 64'h3333_3333_3333_3333,
                  1'b0, 64'h8000_0008, 8'hF0, 64'hCAFE_F00D_0000_0000, 5, 1'b0, 64'h0};
      vecs[9] = '{1'b1, 2'b11, 64'h8000_0020, 64'h0102_0304_0506_0708, 0, 1, 64'h6666_6666_6666_6666,
                  1'b0, 64'h8000_0020, 8'hFF, 64'h0102_0304_0506_0708, 3, 1'b0, 64'h0};
      v_tmo   = '{1'b0, 2'b10, 64'h8000_0000, 64'h0, 0, 99, 64'h7777_7777_7777_7777,
                  1'b0, 64'h8000_0000, 8'h0F, 64'h0, 5, 1'b1, 64'h0};

      // reset state, with an aligned request already presented by EX
      rst = 1'b0; ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 64'h8000_0004;
      ex_wdata = 64'h0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'h1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_ctrl", 64'({bus.mem_req_valid, lsu_done, bus_err, misalign}), 64'd0);
      chk("rst_rdata", dsram_rdata, 64'd0);
      chk("rst_sel_strb", 64'({dsram_sel, bus.mem_wstrb}), 64'd0);
      chk("rst_addr", bus.mem_addr, 64'd0);
      @(negedge clk);
      ex_valid = 1'b0; bus.mem_rsp_valid = 1'b0; rst = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // timeout, then a late response that must be dropped
      run_vec(v_tmo, 10);
      @(negedge clk);
      ex_valid = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'h9999_9999_9999_9999;
      #1;
      chk("late_rsp_done", 64'({lsu_done, stall_req, bus.mem_req_valid}), 64'd0);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("late_rsp_idle", 64'({lsu_done, stall_req, bus_err}), 64'd0);
      chk("late_rsp_rdata", dsram_rdata, 64'd0);
      chk("late_rsp_sel", 64'(dsram_sel), 64'h0F);

      // reset asserted mid-WAIT after a completed load left nonzero read data
      run_vec(vecs[0], 11);
      @(negedge clk);
      ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 64'h8000_0010;
      @(negedge clk);
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      #1;
      chk("mid_wait_stall", 64'(stall_req), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_stall", 64'(stall_req), 64'd0);
      chk("arst_ctrl", 64'({bus.mem_req_valid, lsu_done, bus_err, misalign}), 64'd0);
      chk("arst_rdata", dsram_rdata, 64'd0);
      chk("arst_sel_strb", 64'({dsram_sel, bus.mem_wstrb}), 64'd0);
      chk("arst_addr", bus.mem_addr, 64'd0);
      @(negedge clk);
      rst = 1'b1; ex_valid = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'h4444_4444_4444_4444;
      #1;
      chk("post_rst_rsp", 64'({lsu_done, stall_req}), 64'd0);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("post_rst_idle", 64'({lsu_done, stall_req, bus.mem_req_valid}), 64'd0);
      chk("post_rst_rdata", dsram_rdata, 64'd0);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_2022040010_lsu.md
Name: ysyx_2022040010_lsu

Overview:
- Load/store unit between the execute stage and the memory stage.
- Turns EX's load/store request into a valid/ready transaction on the data SRAM bus, with variable latency. This replaces the zero-latency DPI data-memory path.
- Raises a stall request while the access is outstanding.
- Hands the memory stage the raw 64-bit read beat plus the byte-select mask. The memory stage does byte/half/word extraction and sign extension.

Parameters:
- TIMEOUT, 255, cycles allowed in REQ+WAIT before forcing a bus error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- ex_valid  in  1  EX presents a load/store this cycle.
- ex_we  in  1  1 = store, 0 = load.
- ex_size  in  2  00 byte, 01 half, 10 word, 11 double.
- ex_addr  in  64  byte address.
- ex_wdata  in  64  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_addr  out  64  ex_addr with bits [2:0] cleared.
- mem_we  out  1  write request.
- mem_wdata  out  64  ex_wdata << (8*ex_addr[2:0]).
- mem_wstrb  out  8  byte strobes (equal to dsram_sel).
- mem_rsp_valid  in  1  read data / write ack valid.
- mem_rsp_rdata  in  64  read beat.
- stall_req  out  1  to stall controller; freezes IF..EX.
- lsu_done  out  1  one-cycle pulse when the access completes.
- dsram_rdata  out  64  latched read beat (0 for stores and errors).
- dsram_sel  out  8  byte mask of the completed access.
- bus_err  out  1  pulse with lsu_done on timeout.
- misalign  out  1  one-cycle pulse when a misaligned access is rejected.

Behaviour:
- Reset values (and state while rst=0): state IDLE; all outputs 0; counter 0.
- Byte mask: 8'h01<<a, 8'h03<<a, 8'h0F<<a, or 8'hFF for sizes 00/01/10/11, where a = ex_addr[2:0].
- Misaligned means: half with a[0]≠0, word with a[1:0]≠0, double with a≠0.
- States:
  - IDLE:
    - ex_valid & aligned: latch mem_addr/mem_we/mem_wdata/mem_wstrb/dsram_sel and go to REQ. stall_req=1 combinationally in this same cycle.
    - ex_valid & misaligned: misalign=1 for that cycle, no bus request, stall_req=0, stay IDLE.
    - mem_rsp_valid is ignored in IDLE.
  - REQ:
    - mem_req_valid=1; address, data and strobe held stable until ready.
    - ready & !rsp_valid: go to WAIT.
    - ready & rsp_valid in the same cycle: capture the response and go to DONE.
  - WAIT:
    - mem_req_valid=0.
    - rsp_valid: dsram_rdata <= (mem_we ? 0 : mem_rsp_rdata); go to DONE.
  - DONE:
    - lsu_done=1; stall_req=0, so the pipeline advances this cycle.
    - ex_valid is ignored (it still carries the just-completed instruction).
    - Next state is IDLE.
- stall_req = (IDLE & ex_valid & aligned) | REQ | WAIT.
- Timeout counter:
  - Clears on entry to REQ and increments each cycle in REQ/WAIT.
  - If TIMEOUT≠0 and counter==TIMEOUT-1 with no response: go to DONE with bus_err=1 and dsram_rdata=0.
  - A late response after a timeout arrives in IDLE and is dropped.
- Stores complete on rsp_valid (write ack), exactly like loads.
- dsram_rdata and dsram_sel hold their values until the next completion.
- Reset mid-transaction: asynchronous return to IDLE with outputs 0; any response already in flight is dropped.
- Latency: (cycles to ready) + (cycles to rsp) + 1 DONE cycle. Minimum 2 cycles from acceptance to lsu_done.

Decomposition:
- defines.v gets:
  - LSU_SIZE_B/H/W/D encodings.
  - LSU state encodings IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3.
  - `LSU_TIMEOUT default.
- Sub-module ysyx_2022040010_lsu_align (combinational): size + addr → byte mask, shifted wdata, misalign flag. Reused by the store path and by verification checkers.

Test Plan:
- Aligned load: lw at 0x8000_0004, ready on the 1st cycle of REQ, rsp 2 cycles later with 0x1122_3344_5566_7788 → mem_addr 0x8000_0000, dsram_sel 8'hF0, dsram_rdata 0x1122_3344_5566_7788, stall_req high 4 cycles, lsu_done pulse.
- Byte store: sb at 0x8000_0003 with wdata 0xAB → mem_we=1, mem_wstrb 8'h08, mem_wdata 0x0000_0000_AB00_0000; ack → lsu_done, dsram_rdata 0.
- Misaligned access: lw at 0x8000_0002 → misalign pulse, mem_req_valid never asserted, stall_req 0.
- Zero-latency bus: ready and rsp_valid in the first REQ cycle for ld at 0x8000_0008 → DONE next cycle, dsram_sel 8'hFF, total stall 2 cycles.
- Timeout: TIMEOUT=4, ready=1, rsp never arrives → bus_err and lsu_done together after 4 counted cycles, dsram_rdata 0; a later rsp_valid is ignored.
- Reset mid-access: rst=0 during WAIT → all outputs 0 immediately (asynchronously); after release, a pending rsp_valid is ignored and state stays IDLE.
